// File: rtl/register_bank.sv
// register_bank
//   Bank of NREGS bus registers (A/X/Y/S class) sharing one tri-state data bus.
//   Every clock edge applies one operation to the register picked by sel:
//   hold, load from the bus, increment or decrement. Z/N flags describe the
//   result of the last executed operation; wrap pulses for one cycle when an
//   increment or decrement rolls over.
//
// Parameters
//   WIDTH      bits per register and width of the data bus
//   NREGS      number of registers (>=1)
//   SELW       select width, 2**SELW >= NREGS
//   RESET_VAL  value every register takes on reset
//
// Ports
//   clk     in     rising-edge clock
//   rst_n   in     asynchronous active-low reset
//   data    inout  shared tri-state data bus
//   op      in     00 hold, 01 load, 10 inc, 11 dec (applied to sel)
//   sel     in     target register for op
//   oe      in     drive data with register oe_sel
//   oe_sel  in     register placed on data when oe=1
//   z       out    result of last executed op was zero
//   n       out    MSB of result of last executed op
//   wrap    out    one-cycle pulse on inc from all-ones or dec from zero

module register_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 NREGS     = 4,
    parameter int                 SELW      = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [WIDTH-1:0]  data,
    input  logic [1:0]        op,
    input  logic [SELW-1:0]   sel,
    input  logic              oe,
    input  logic [SELW-1:0]   oe_sel,
    output logic              z,
    output logic              n,
    output logic              wrap
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [NREGS];

    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] result;
    logic             sel_ok;
    logic             write_en;
    logic             wrap_next;

    // Bus read mux. An out-of-range oe_sel reads as zero so the bus is
    // never left floating while oe is asserted.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (oe_sel == SELW'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    // Bus drive depends on oe only; reset does not tri-state it.
    assign data = oe ? rd_val : 'z;

    // Operation datapath. A load takes the resolved bus value, so with oe=1
    // it becomes a one-cycle register-to-register transfer.
    always_comb begin
        sel_ok  = 1'b0;
        cur_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel == SELW'(i)) begin
                sel_ok  = 1'b1;
                cur_val = regs[i];
            end
        end

        result    = cur_val;
        wrap_next = 1'b0;
        case (op)
            OP_LOAD: result = data;
            OP_INC: begin
                result    = cur_val + ONE;
                wrap_next = (cur_val == ALL_ONES);
            end
            OP_DEC: begin
                result    = cur_val - ONE;
                wrap_next = (cur_val == '0);
            end
            default: result = cur_val;
        endcase

        // Non-existent targets are ignored entirely: no write, flags held.
        write_en = sel_ok && (op != OP_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            z    <= (RESET_VAL == '0);
            n    <= RESET_VAL[WIDTH-1];
            wrap <= 1'b0;
        end else begin
            wrap <= write_en && wrap_next;
            if (write_en) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (sel == SELW'(i)) begin
                        regs[i] <= result;
                    end
                end
                z <= (result == '0);
                n <= result[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank
//   Directed bench for register_bank. A 4-register instance is checked
//   against a behavioural model every cycle plus literal expectations; a
//   3-register instance covers out-of-range selects with literal checks.

module tb_register_bank;

    localparam int W = 8;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] INC  = 2'b10;
    localparam logic [1:0] DEC  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- 4-register instance ----------------
    wire  [W-1:0] data;
    logic [1:0]   op;
    logic [1:0]   sel;
    logic         oe;
    logic [1:0]   oe_sel;
    logic         z, n, wrap;
    logic         ext_en;
    logic [W-1:0] ext_val;

    assign data = ext_en ? ext_val : 'z;

    register_bank #(.WIDTH(W), .NREGS(4), .SELW(2), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .op(op), .sel(sel),
        .oe(oe), .oe_sel(oe_sel), .z(z), .n(n), .wrap(wrap)
    );

    // ---------------- 3-register instance ----------------
    wire  [W-1:0] data3;
    logic [1:0]   op3;
    logic [1:0]   sel3;
    logic         oe3;
    logic [1:0]   oe_sel3;
    logic         z3, n3, wrap3;
    logic         ext3_en;
    logic [W-1:0] ext3_val;

    assign data3 = ext3_en ? ext3_val : 'z;

    register_bank #(.WIDTH(W), .NREGS(3), .SELW(2), .RESET_VAL(8'h00)) dut3 (
        .clk(clk), .rst_n(rst_n), .data(data3), .op(op3), .sel(sel3),
        .oe(oe3), .oe_sel(oe_sel3), .z(z3), .n(n3), .wrap(wrap3)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic check_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_regs [4];
    logic         m_z, m_n, m_wrap;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_z    = 1'b1;
        m_n    = 1'b0;
        m_wrap = 1'b0;
    endtask

    // Applies the operation presented at the clock edge.
    task automatic model_step();
        logic [W-1:0] bus_val;
        logic [W-1:0] old_val;
        logic [W-1:0] res;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (op == HOLD) begin
            m_wrap = 1'b0;
            return;
        end
        bus_val = ext_en ? ext_val : m_regs[oe_sel];
        old_val = m_regs[sel];
        if (op == LOAD)     res = bus_val;
        else if (op == INC) res = W'((int'(old_val) + 1) % 256);
        else                res = W'((int'(old_val) + 255) % 256);
        m_wrap       = (op == INC && old_val == 8'hFF) || (op == DEC && old_val == 8'h00);
        m_regs[sel]  = res;
        m_z          = (res == 8'h00);
        m_n          = (res >= 8'h80);
    endtask

    // Per-cycle compare of the 4-register instance against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_z", W'(z), W'(m_z));
            check("cyc_n", W'(n), W'(m_n));
            check("cyc_wrap", W'(wrap), W'(m_wrap));
            if (oe && !ext_en) check("cyc_data", data, m_regs[oe_sel]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic [1:0] o, input logic [1:0] s, input logic e,
                         input logic [1:0] es, input logic xe, input logic [W-1:0] xv);
        op = o; sel = s; oe = e; oe_sel = es; ext_en = xe; ext_val = xv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycle3(input logic [1:0] o, input logic [1:0] s, input logic e,
                          input logic [1:0] es, input logic xe, input logic [W-1:0] xv);
        op3 = o; sel3 = s; oe3 = e; oe_sel3 = es; ext3_en = xe; ext3_val = xv;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b1;
        op = HOLD; sel = 2'd0; oe = 1'b1; oe_sel = 2'd2; ext_en = 1'b0; ext_val = '0;
        op3 = HOLD; sel3 = 2'd0; oe3 = 1'b0; oe_sel3 = 2'd0; ext3_en = 1'b0; ext3_val = '0;
        model_reset();

        // 1: asynchronous reset state
        #1 rst_n = 1'b0;
        #2;
        check("t1_data", data, 8'h00);
        check("t1_z", W'(z), 8'h01);
        check("t1_n", W'(n), 8'h00);
        check("t1_wrap", W'(wrap), 8'h00);
        #9 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_en = 1'b1;

        // 2: external load into reg1, then read it back
        cycle(LOAD, 2'd1, 1'b0, 2'd0, 1'b1, 8'h80);
        check("t2_z", W'(z), 8'h00);
        check("t2_n", W'(n), 8'h01);
        cycle(HOLD, 2'd0, 1'b1, 2'd1, 1'b0, 8'h00);
        check("t2_data", data, 8'h80);

        // 3: wrap on inc from FF and dec from 00
        cycle(LOAD, 2'd0, 1'b0, 2'd0, 1'b1, 8'hFF);
        cycle(INC, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        check("t3_inc_data", data, 8'h00);
        check("t3_inc_z", W'(z), 8'h01);
        check("t3_inc_wrap", W'(wrap), 8'h01);
        cycle(DEC, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        check("t3_dec_data", data, 8'hFF);
        check("t3_dec_n", W'(n), 8'h01);
        check("t3_dec_wrap", W'(wrap), 8'h01);
        cycle(HOLD, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        check("t3_hold_wrap", W'(wrap), 8'h00);

        // self-transfer: value unchanged, flags still update
        cycle(INC, 2'd0, 1'b0, 2'd0, 1'b0, 8'h00);
        check("self_pre_z", W'(z), 8'h01);
        cycle(LOAD, 2'd1, 1'b1, 2'd1, 1'b0, 8'h00);
        check("self_z", W'(z), 8'h00);
        check("self_n", W'(n), 8'h01);
        cycle(HOLD, 2'd0, 1'b1, 2'd1, 1'b0, 8'h00);
        check("self_data", data, 8'h80);

        // 4: transfer reg2 -> reg3 over the bus
        cycle(LOAD, 2'd2, 1'b0, 2'd0, 1'b1, 8'h3C);
        cycle(LOAD, 2'd3, 1'b1, 2'd2, 1'b0, 8'h00);
        check("t4_z", W'(z), 8'h00);
        check("t4_n", W'(n), 8'h00);
        cycle(HOLD, 2'd0, 1'b1, 2'd3, 1'b0, 8'h00);
        check("t4_reg3", data, 8'h3C);
        cycle(HOLD, 2'd0, 1'b1, 2'd2, 1'b0, 8'h00);
        check("t4_reg2", data, 8'h3C);

        // inc/dec on a read-while-modified register; other registers hold
        cycle(INC, 2'd1, 1'b1, 2'd1, 1'b0, 8'h00);
        cycle(INC, 2'd1, 1'b1, 2'd1, 1'b0, 8'h00);
        cycle(DEC, 2'd2, 1'b1, 2'd1, 1'b0, 8'h00);
        check("rmw_reg1", data, 8'h82);
        cycle(HOLD, 2'd0, 1'b1, 2'd2, 1'b0, 8'h00);
        check("rmw_reg2", data, 8'h3B);

        // 6: reset pulse between edges during an inc stream on reg0
        cycle(LOAD, 2'd0, 1'b0, 2'd0, 1'b1, 8'h10);
        cycle(INC, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        cycle(INC, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        cycle(INC, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        check("t6_pre", data, 8'h13);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_data", data, 8'h00);
        check("t6_rst_z", W'(z), 8'h01);
        check("t6_rst_n", W'(n), 8'h00);
        rst_n = 1'b1;
        cycle(INC, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        check("t6_restart", data, 8'h01);
        cycle(HOLD, 2'd0, 1'b1, 2'd3, 1'b0, 8'h00);
        check("t6_reg3", data, 8'h00);
        check_en = 1'b0;

        // 5: three-register bank, select of a missing register
        cycle3(LOAD, 2'd0, 1'b0, 2'd0, 1'b1, 8'h81);
        check("t5_load_z", W'(z3), 8'h00);
        check("t5_load_n", W'(n3), 8'h01);
        cycle3(DEC, 2'd1, 1'b0, 2'd0, 1'b0, 8'h00);
        check("t5_dec_wrap", W'(wrap3), 8'h01);
        cycle3(INC, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00);
        check("t5_bad_wrap", W'(wrap3), 8'h00);
        check("t5_bad_z", W'(z3), 8'h00);
        check("t5_bad_n", W'(n3), 8'h01);
        cycle3(HOLD, 2'd0, 1'b1, 2'd3, 1'b0, 8'h00);
        check("t5_bad_data", data3, 8'h00);
        cycle3(HOLD, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00);
        check("t5_reg0", data3, 8'h81);
        cycle3(HOLD, 2'd0, 1'b1, 2'd1, 1'b0, 8'h00);
        check("t5_reg1", data3, 8'hFF);
        cycle3(HOLD, 2'd0, 1'b1, 2'd2, 1'b0, 8'h00);
        check("t5_reg2", data3, 8'h00);
        cycle3(LOAD, 2'd2, 1'b0, 2'd0, 1'b1, 8'h00);
        check("t5_zero_z", W'(z3), 8'h01);
        cycle3(DEC, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00);
        check("t5_bad_dec_wrap", W'(wrap3), 8'h00);
        check("t5_bad_dec_z", W'(z3), 8'h01);
        check("t5_bad_dec_n", W'(n3), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
